// File: rtl/handshake_fifo_buffer.sv
// Elastic valid/ready FIFO that puts a registered boundary between producer and consumer.
// Optional zero-latency pass-through when empty: define HANDSHAKE_FIFO_BYPASS_EN.
module handshake_fifo_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_WIDTH-1:0]        ins,
   input  logic                         ins_valid,
   output logic                         ins_ready,
   output logic [DATA_WIDTH-1:0]        outs,
   output logic                         outs_valid,
   input  logic                         outs_ready,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_d;
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      count_d;
   // Low while in reset, high from the first edge after release; keeps ins_ready register-driven.
   logic                  run_q;

   logic                  empty_s;
   logic                  full_s;
   logic                  ins_ready_s;
   logic                  push_s;
   logic                  pop_s;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
   logic                  bypass_s;
`endif

   // Handshake qualification from registered state only.
   always_comb begin
      empty_s     = (count_q == '0);
      full_s      = (count_q == CNT_FULL);
      ins_ready_s = run_q && !full_s;
      pop_s       = !empty_s && outs_ready;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
      bypass_s    = empty_s && ins_valid && ins_ready_s && outs_ready;
      push_s      = ins_valid && ins_ready_s && !bypass_s;
`else
      push_s      = ins_valid && ins_ready_s;
`endif
   end

   // Next-state for pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Control state register, flushed asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         run_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         run_q    <= 1'b1;
      end
   end

   // Token storage; contents are meaningless until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= ins;
      end
   end

   // Output drive.
   always_comb begin
      ins_ready = ins_ready_s;
      occupancy = count_q;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
      if (empty_s) begin
         outs       = ins;
         outs_valid = ins_valid && ins_ready_s;
      end else begin
         outs       = mem_q[rd_ptr_q];
         outs_valid = 1'b1;
      end
`else
      outs       = mem_q[rd_ptr_q];
      outs_valid = !empty_s;
`endif
   end

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Self-checking bench for handshake_fifo_buffer: fixed vector table, directed corner
// sequences and random back-pressure against a queue-based reference model.
module tb_handshake_fifo_buffer;

   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk;
   logic          rst;
   logic [DW-1:0] ins;
   logic          ins_valid;
   logic          ins_ready;
   logic [DW-1:0] outs;
   logic          outs_valid;
   logic          outs_ready;
   logic [2:0]    occupancy;

   int errors;
   int checks;

   logic [DW-1:0] model_q[$];
   logic          m_run;

   typedef struct {
      logic          iv;
      logic [DW-1:0] din;
      logic          ordy;
      logic          exp_valid;
      logic          exp_ready;
      logic [2:0]    exp_occ;
      logic [DW-1:0] exp_outs;
   } vec_t;

   vec_t vecs[10];

   handshake_fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .ins        (ins),
      .ins_valid  (ins_valid),
      .ins_ready  (ins_ready),
      .outs       (outs),
      .outs_valid (outs_valid),
      .outs_ready (outs_ready),
      .occupancy  (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk_bit("m_ins_ready", ins_ready, m_run && (model_q.size() < DEPTH));
      chk_bit("m_outs_valid", outs_valid, model_q.size() != 0);
      chk_val("m_occupancy", {29'd0, occupancy}, 32'(model_q.size()));
      if (model_q.size() != 0) begin
         chk_val("m_outs", outs, model_q[0]);
      end
   endtask

   // Called at a negedge: drive inputs, take one rising edge, update model, check at next negedge.
   task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic ordy);
      logic m_push;
      logic m_pop;
      ins_valid  = iv;
      ins        = d;
      outs_ready = ordy;
      m_push = iv && m_run && (model_q.size() < DEPTH);
      m_pop  = ordy && (model_q.size() != 0);
      @(posedge clk);
      if (m_pop) begin
         void'(model_q.pop_front());
      end
      if (m_push) begin
         model_q.push_back(d);
      end
      m_run = !rst;
      @(negedge clk);
      check_model();
   endtask

   initial begin
      logic [31:0]   r;
      logic          stalled;
      logic [DW-1:0] held;

      errors = 0;
      checks = 0;
      m_run  = 1'b0;

      vecs[0] = '{1'b1, 32'd1, 1'b0, 1'b1, 1'b1, 3'd1, 32'd1};
      vecs[1] = '{1'b1, 32'd2, 1'b0, 1'b1, 1'b1, 3'd2, 32'd1};
      vecs[2] = '{1'b1, 32'd3, 1'b0, 1'b1, 1'b1, 3'd3, 32'd1};
      vecs[3] = '{1'b1, 32'd4, 1'b0, 1'b1, 1'b0, 3'd4, 32'd1};
      vecs[4] = '{1'b1, 32'd5, 1'b0, 1'b1, 1'b0, 3'd4, 32'd1};
      vecs[5] = '{1'b1, 32'd5, 1'b1, 1'b1, 1'b1, 3'd3, 32'd2};
      vecs[6] = '{1'b1, 32'd5, 1'b1, 1'b1, 1'b1, 3'd3, 32'd3};
      vecs[7] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 3'd2, 32'd4};
      vecs[8] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 3'd1, 32'd5};
      vecs[9] = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 3'd0, 32'd0};

      // Reset
      rst        = 1'b1;
      ins        = '0;
      ins_valid  = 1'b0;
      outs_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk_bit("rst_outs_valid", outs_valid, 1'b0);
      chk_bit("rst_ins_ready", ins_ready, 1'b0);
      chk_val("rst_occupancy", {29'd0, occupancy}, 32'd0);
      rst = 1'b0;
      cycle(1'b0, 32'd0, 1'b0);
      chk_bit("post_rst_ins_ready", ins_ready, 1'b1);
      chk_bit("post_rst_outs_valid", outs_valid, 1'b0);
      cycle(1'b0, 32'd0, 1'b1);
      chk_val("idle_occupancy", {29'd0, occupancy}, 32'd0);

      // Single token, one-cycle latency
      cycle(1'b1, 32'hE8C, 1'b1);
      chk_val("single_outs", outs, 32'hE8C);
      chk_bit("single_valid", outs_valid, 1'b1);
      chk_val("single_occ1", {29'd0, occupancy}, 32'd1);
      cycle(1'b0, 32'd0, 1'b1);
      chk_val("single_occ0", {29'd0, occupancy}, 32'd0);
      chk_bit("single_empty", outs_valid, 1'b0);

      // Fill, hold-off, drain from the vector table
      for (int i = 0; i < 10; i++) begin
         cycle(vecs[i].iv, vecs[i].din, vecs[i].ordy);
         chk_bit($sformatf("tbl%0d_valid", i), outs_valid, vecs[i].exp_valid);
         chk_bit($sformatf("tbl%0d_ready", i), ins_ready, vecs[i].exp_ready);
         chk_val($sformatf("tbl%0d_occ", i), {29'd0, occupancy}, {29'd0, vecs[i].exp_occ});
         if (vecs[i].exp_valid) begin
            chk_val($sformatf("tbl%0d_outs", i), outs, vecs[i].exp_outs);
         end
      end

      // Streaming: one token per cycle, occupancy settles at 1
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 32'(i), 1'b1);
         chk_val("stream_outs", outs, 32'(i));
         chk_val("stream_occ", {29'd0, occupancy}, 32'd1);
      end
      cycle(1'b0, 32'd0, 1'b1);
      chk_val("stream_drain_occ", {29'd0, occupancy}, 32'd0);

      // Random back-pressure
      for (int i = 0; i < 1000; i++) begin
         r       = $urandom;
         stalled = outs_valid && !r[1];
         held    = outs;
         cycle(r[0] | r[2], $urandom, r[1]);
         if (stalled) begin
            chk_bit("stall_valid", outs_valid, 1'b1);
            chk_val("stall_outs", outs, held);
         end
      end
      while (model_q.size() != 0) begin
         cycle(1'b0, 32'd0, 1'b1);
      end

      // Asynchronous reset mid-cycle with three tokens stored
      cycle(1'b1, 32'h11, 1'b0);
      cycle(1'b1, 32'h22, 1'b0);
      cycle(1'b1, 32'h33, 1'b0);
      chk_val("pre_flush_occ", {29'd0, occupancy}, 32'd3);
      #2;
      rst = 1'b1;
      #1;
      chk_bit("flush_outs_valid", outs_valid, 1'b0);
      chk_bit("flush_ins_ready", ins_ready, 1'b0);
      chk_val("flush_occ", {29'd0, occupancy}, 32'd0);
      model_q.delete();
      m_run = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_val("flush_hold_occ", {29'd0, occupancy}, 32'd0);
      rst = 1'b0;
      cycle(1'b0, 32'd0, 1'b0);
      chk_bit("rerun_ready", ins_ready, 1'b1);
      cycle(1'b1, 32'hABC, 1'b0);
      chk_val("rerun_first_outs", outs, 32'hABC);
      chk_bit("rerun_valid", outs_valid, 1'b1);
      cycle(1'b0, 32'd0, 1'b1);
      chk_val("rerun_drain_occ", {29'd0, occupancy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
